// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: states, opcodes,
// select codes, the instruction-class struct and small select helpers.
package mc_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic bad;
  } opclass_t;

  function automatic logic [2:0] imm_sel_of(opclass_t c);
    if (c.store)               return IMM_S;
    else if (c.branch)         return IMM_B;
    else if (c.lui || c.auipc) return IMM_U;
    else if (c.jal)            return IMM_J;
    else                       return IMM_I;
  endfunction

  function automatic logic [1:0] wb_sel_of(opclass_t c);
    if (c.jal || c.jalr) return WB_LINK;
    else if (c.load)     return WB_MEM;
    else if (c.lui)      return WB_IMM;
    else                 return WB_ALU;
  endfunction

endpackage

// File: rtl/mc_opclass_dec.sv
// Opcode to one-hot instruction class; anything unrecognised flags bad.
module mc_opclass_dec
  import mc_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.alu_r  = 1'b1;
      OP_I:      cls.alu_i  = 1'b1;
      OP_LOAD:   cls.load   = 1'b1;
      OP_STORE:  cls.store  = 1'b1;
      OP_BRANCH: cls.branch = 1'b1;
      OP_JAL:    cls.jal    = 1'b1;
      OP_JALR:   cls.jalr   = 1'b1;
      OP_LUI:    cls.lui    = 1'b1;
      OP_AUIPC:  cls.auipc  = 1'b1;
      default:   cls.bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory req/ready
// handshake, debug halt at instruction boundary, sticky trap and instret.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             br_taken,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       imm_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  state_t   state;
  opclass_t cls_d, cls_q, cls;
  logic     retire;

  mc_opclass_dec u_dec (
    .opcode (opcode),
    .cls    (cls_d)
  );

  // Class is taken live from the IR in DECODE, then held for the rest of the instruction.
  assign cls = (state == S_DECODE) ? cls_d : cls_q;

  assign retire = !rst && ((state == S_EXEC && cls.branch) ||
                           (state == S_MEM && cls.store && mem_ready) ||
                           (state == S_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cls_q   <= '0;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          cls_q <= cls_d;
          state <= cls_d.bad ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          if (cls.branch)                state <= halt_req ? S_HALT : S_FETCH;
          else if (cls.load || cls.store) state <= S_MEM;
          else                           state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (cls.store) state <= halt_req ? S_HALT : S_FETCH;
            else           state <= S_WB;
          end
        end
        S_WB:     state <= halt_req ? S_HALT : S_FETCH;
        S_HALT:   if (!halt_req) state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Decoded from state and held class; rst forces everything quiet, including mid-access.
  always_comb begin
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    imm_sel   = IMM_I;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
        imm_sel   = imm_sel_of(cls);
        alu_src_a = cls.auipc;
        alu_src_b = cls.alu_i | cls.load | cls.store | cls.jalr | cls.auipc | cls.lui;
      end
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        S_EXEC: begin
          if (cls.branch && br_taken) begin
            pc_we  = 1'b1;
            pc_src = PC_REL;
          end else if (cls.jal) begin
            pc_we  = 1'b1;
            pc_src = PC_REL;
          end else if (cls.jalr) begin
            pc_we  = 1'b1;
            pc_src = PC_ALU;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = cls.store;
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = wb_sel_of(cls);
        end
        S_HALT:  halted  = 1'b1;
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with a 3-bit instret so wrap is reachable.
module tb_mc_control_fsm;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             mem_ready, br_taken, halt_req;
  logic             mem_req, mem_sel, mem_we, ir_we, pc_we;
  logic [1:0]       pc_src, wb_sel;
  logic [2:0]       imm_sel;
  logic             alu_src_a, alu_src_b, reg_we, illegal, halted;
  logic [CNT_W-1:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .br_taken  (br_taken),
    .halt_req  (halt_req),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .imm_sel   (imm_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .illegal   (illegal),
    .halted    (halted),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; mem_ready = 1'b1; br_taken = 1'b0; halt_req = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_pc_we", pc_we, 0);
    step();
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0;

    // ADDI, zero-wait memory: FETCH, DECODE, EXEC, WB
    opcode = 7'd19; #1;
    chk("addi_f_req", mem_req, 1); chk("addi_f_sel", mem_sel, 0);
    chk("addi_f_irwe", ir_we, 1); chk("addi_f_pcwe", pc_we, 1); chk("addi_f_pcsrc", pc_src, 0);
    step();
    chk("addi_d_req", mem_req, 0); chk("addi_d_irwe", ir_we, 0); chk("addi_d_imm", imm_sel, 0);
    step();
    chk("addi_e_srcb", alu_src_b, 1); chk("addi_e_regwe", reg_we, 0); chk("addi_e_pcwe", pc_we, 0);
    step();
    chk("addi_w_regwe", reg_we, 1); chk("addi_w_wbsel", wb_sel, 0); chk("addi_w_ret", instret, 0);
    step();
    chk("addi_ret", instret, 1); chk("addi_next_f", mem_req, 1);

    // LW: fetch waits 3 cycles, data ready at once
    opcode = 7'd3; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_fwait_req", mem_req, 1); chk("lw_fwait_irwe", ir_we, 0);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("lw_f_req", mem_req, 1); chk("lw_f_irwe", ir_we, 1);
    step();
    chk("lw_d_imm", imm_sel, 0);
    step();
    chk("lw_e_req", mem_req, 0); chk("lw_e_srcb", alu_src_b, 1);
    step();
    chk("lw_m_req", mem_req, 1); chk("lw_m_sel", mem_sel, 1); chk("lw_m_we", mem_we, 0);
    step();
    chk("lw_w_regwe", reg_we, 1); chk("lw_w_wbsel", wb_sel, 1);
    step();
    chk("lw_ret", instret, 2);

    // BEQ taken: retire at EXEC
    opcode = 7'd99; br_taken = 1'b1;
    step();
    chk("beq_d_imm", imm_sel, 2);
    step();
    chk("beq_e_pcwe", pc_we, 1); chk("beq_e_pcsrc", pc_src, 1); chk("beq_e_regwe", reg_we, 0);
    step();
    chk("beq_ret", instret, 3); chk("beq_next_f", mem_req, 1);

    // BEQ not taken: still retires, no PC write in EXEC
    br_taken = 1'b0;
    step(); step();
    chk("bne_e_pcwe", pc_we, 0);
    step();
    chk("bne_ret", instret, 4);

    // JAL
    opcode = 7'd111;
    step();
    chk("jal_d_imm", imm_sel, 4);
    step();
    chk("jal_e_pcwe", pc_we, 1); chk("jal_e_pcsrc", pc_src, 1);
    step();
    chk("jal_w_regwe", reg_we, 1); chk("jal_w_wbsel", wb_sel, 2); chk("jal_w_pcwe", pc_we, 0);
    step();
    chk("jal_ret", instret, 5);

    // STORE with one wait cycle, halt requested on the completing cycle
    opcode = 7'd35;
    step();
    chk("sw_d_imm", imm_sel, 1);
    step();
    chk("sw_e_req", mem_req, 0);
    mem_ready = 1'b0;
    step();
    chk("sw_mwait_req", mem_req, 1); chk("sw_mwait_we", mem_we, 1); chk("sw_mwait_sel", mem_sel, 1);
    step();
    chk("sw_mhold_we", mem_we, 1);
    mem_ready = 1'b1; halt_req = 1'b1; #1;
    chk("sw_mrdy_req", mem_req, 1);
    step();
    chk("halt_halted", halted, 1); chk("halt_req_lo", mem_req, 0); chk("halt_ret", instret, 6);
    step();
    chk("halt_stay", halted, 1); chk("halt_stay_irwe", ir_we, 0);
    halt_req = 1'b0;
    step();
    chk("halt_rel_f", halted, 0); chk("halt_rel_req", mem_req, 1);

    // JALR then LUI: the LUI retire wraps instret 7 -> 0
    opcode = 7'd103;
    step(); step();
    chk("jalr_e_pcwe", pc_we, 1); chk("jalr_e_pcsrc", pc_src, 2);
    step();
    chk("jalr_w_wbsel", wb_sel, 2);
    step();
    chk("jalr_ret", instret, 7);
    opcode = 7'd55;
    step(); step(); step();
    chk("lui_w_regwe", reg_we, 1); chk("lui_w_wbsel", wb_sel, 3);
    step();
    chk("lui_wrap", instret, 0);

    // AUIPC selects OLD_PC on ALU input A
    opcode = 7'd23;
    step(); step();
    chk("auipc_e_srca", alu_src_a, 1);
    step(); step();
    chk("auipc_ret", instret, 1);

    // Illegal opcode traps and sticks; instret frozen
    opcode = 7'h7F;
    step();
    chk("trap_d_illegal", illegal, 0);
    step();
    chk("trap_illegal", illegal, 1); chk("trap_req", mem_req, 0);
    step(); step();
    chk("trap_sticky", illegal, 1); chk("trap_ret", instret, 1);
    rst = 1'b1; #1;
    chk("trap_rst_illegal", illegal, 0);
    step();
    rst = 1'b0;

    // Reset during a data-access wait aborts it
    opcode = 7'd3;
    step(); step(); step();
    mem_ready = 1'b0; #1;
    chk("rstmem_wait_req", mem_req, 1); chk("rstmem_wait_sel", mem_sel, 1);
    rst = 1'b1; #1;
    chk("rstmem_req", mem_req, 0); chk("rstmem_sel", mem_sel, 0);
    step();
    rst = 1'b0; #1;
    chk("rstmem_f_req", mem_req, 1); chk("rstmem_f_sel", mem_sel, 0); chk("rstmem_ret", instret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
